// File: rtl/sqrt_formula_pkg.sv
// sqrt_formula_pkg: shared FSM state type and default sizing for formula_sum_isqrt_fsm.
package sqrt_formula_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam int N_ARGS_DEF  = 3;
    localparam int N_ISQRT_DEF = 2;
    localparam int W_DEF       = 32;
endpackage

// File: rtl/isqrt_lane_sum.sv
// isqrt_lane_sum: zero-extends each lane root and sums the lanes selected by act.
module isqrt_lane_sum #(
    parameter int N_ISQRT = 2,
    parameter int W       = 32
) (
    input  logic [N_ISQRT-1:0][W/2-1:0] y,
    input  logic [N_ISQRT-1:0]          act,
    output logic [W-1:0]                sum
);
    always_comb begin
        sum = '0;
        for (int j = 0; j < N_ISQRT; j++) sum = sum + (act[j] ? W'(y[j]) : '0);
    end
endmodule

// File: rtl/formula_sum_isqrt_fsm.sv
// formula_sum_isqrt_fsm: sums isqrt(arg[i]) over all arguments by issuing batches
// to N_ISQRT external isqrt lanes and accumulating their roots modulo 2^W.
module formula_sum_isqrt_fsm
    import sqrt_formula_pkg::*;
#(
    parameter int N_ARGS  = N_ARGS_DEF,
    parameter int N_ISQRT = N_ISQRT_DEF,
    parameter int W       = W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          arg_vld,
    input  logic [N_ARGS-1:0][W-1:0]      arg,
    output logic                          arg_rdy,
    output logic                          res_vld,
    output logic [W-1:0]                  res,
    output logic [N_ISQRT-1:0]            isqrt_x_vld,
    output logic [N_ISQRT-1:0][W-1:0]     isqrt_x,
    input  logic [N_ISQRT-1:0]            isqrt_y_vld,
    input  logic [N_ISQRT-1:0][W/2-1:0]   isqrt_y
);
    localparam int B  = (N_ARGS + N_ISQRT - 1) / N_ISQRT;
    localparam int BW = B > 1 ? $clog2(B) : 1;
    localparam int PW = B * N_ISQRT * W;

    if (N_ARGS < 1 || N_ARGS > 16 || N_ISQRT < 1 || N_ISQRT > N_ARGS ||
        W < 8 || W > 64 || W % 2 != 0) begin : g_bad_param
        $fatal(1, "formula_sum_isqrt_fsm: illegal parameter set");
    end

    state_t                             r_state, w_next;
    logic [B-1:0][N_ISQRT-1:0][W-1:0]   r_arg;
    logic [BW-1:0]                      r_batch;
    logic [W-1:0]                       r_acc, r_res, w_sum;
    logic                               r_res_vld, w_done, w_last;
    logic [N_ISQRT-1:0]                 w_act;

    // Arguments are stored zero-padded to whole batches so a batch is a plain index.
    always_comb begin
        w_act = '0;
        for (int j = 0; j < N_ISQRT; j++) w_act[j] = (int'(r_batch) * N_ISQRT + j) < N_ARGS;
    end

    assign w_last      = r_batch == BW'(B - 1);
    assign w_done      = (r_state == WAIT) && ((isqrt_y_vld & w_act) == w_act);
    assign isqrt_x_vld = w_act & {N_ISQRT{r_state == ISSUE}};
    assign arg_rdy     = r_state == IDLE;
    assign res_vld     = r_res_vld;
    assign res         = r_res;

    always_comb begin
        isqrt_x = '0;
        for (int j = 0; j < N_ISQRT; j++) isqrt_x[j] = isqrt_x_vld[j] ? r_arg[r_batch][j] : '0;
    end

    isqrt_lane_sum #(.N_ISQRT(N_ISQRT), .W(W)) u_lane_sum (
        .y   (isqrt_y),
        .act (w_act),
        .sum (w_sum)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = arg_vld ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = w_done ? (w_last ? DONE : ISSUE) : WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_arg     <= '0;
            r_batch   <= '0;
            r_acc     <= '0;
            r_res     <= '0;
            r_res_vld <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_res_vld <= w_next == DONE;
            if (r_state == IDLE && arg_vld) begin
                r_arg   <= PW'(arg);
                r_acc   <= '0;
                r_batch <= '0;
            end
            if (w_done) begin
                r_acc <= r_acc + w_sum;
                if (w_last) r_res <= r_acc + w_sum;
                else r_batch <= r_batch + BW'(1);
            end
        end
    end
endmodule

// File: tb/tb_formula_sum_isqrt_fsm.sv
// tb_formula_sum_isqrt_fsm: directed and random checks of the batched isqrt summer
// against behavioural isqrt lanes with programmable latency.
module tb_formula_sum_isqrt_fsm;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    int n_tot = 0, n_bad = 0, lat = 4, skew = 0;

    logic              arg_vld = 0, arg_rdy, res_vld;
    logic [2:0][31:0]  arg = '0;
    logic [31:0]       res;
    logic [1:0]        xa_vld, ya_vld;
    logic [1:0][31:0]  xa;
    logic [1:0][15:0]  ya;

    logic              argb_vld = 0, argb_rdy, resb_vld;
    logic [3:0][31:0]  argb = '0;
    logic [31:0]       resb;
    logic [3:0]        xb_vld, yb_vld;
    logic [3:0][31:0]  xb;
    logic [3:0][15:0]  yb;

    formula_sum_isqrt_fsm u_dut (
        .clk(clk), .rst_n(rst_n), .arg_vld(arg_vld), .arg(arg), .arg_rdy(arg_rdy),
        .res_vld(res_vld), .res(res), .isqrt_x_vld(xa_vld), .isqrt_x(xa),
        .isqrt_y_vld(ya_vld), .isqrt_y(ya)
    );

    formula_sum_isqrt_fsm #(.N_ARGS(4), .N_ISQRT(4), .W(32)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .arg_vld(argb_vld), .arg(argb), .arg_rdy(argb_rdy),
        .res_vld(resb_vld), .res(resb), .isqrt_x_vld(xb_vld), .isqrt_x(xb),
        .isqrt_y_vld(yb_vld), .isqrt_y(yb)
    );

    function automatic logic [15:0] isq(input logic [31:0] x);
        logic [15:0] r = '0;
        for (int b = 15; b >= 0; b--) begin
            logic [15:0] t = r | (16'd1 << b);
            if (64'(t) * 64'(t) <= 64'(x)) r = t;
        end
        return r;
    endfunction

    // Lane models hold y_vld from completion until the next request; roots read as junk otherwise.
    int cnta[2], cntb[4];
    logic pa[2], pb[4];
    logic [15:0] ra[2], rb[4];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < 2; j++) begin pa[j] <= 0; cnta[j] <= 0; ra[j] <= '0; end
            for (int j = 0; j < 4; j++) begin pb[j] <= 0; cntb[j] <= 0; rb[j] <= '0; end
        end else begin
            for (int j = 0; j < 2; j++)
                if (xa_vld[j]) begin pa[j] <= 1; cnta[j] <= lat + skew * j - 1; ra[j] <= isq(xa[j]); end
                else if (cnta[j] > 0) cnta[j] <= cnta[j] - 1;
            for (int j = 0; j < 4; j++)
                if (xb_vld[j]) begin pb[j] <= 1; cntb[j] <= lat - 1; rb[j] <= isq(xb[j]); end
                else if (cntb[j] > 0) cntb[j] <= cntb[j] - 1;
        end
    end
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            ya_vld[j] = pa[j] && cnta[j] == 0;
            ya[j] = ya_vld[j] ? ra[j] : 16'hDEAD;
        end
        for (int j = 0; j < 4; j++) begin
            yb_vld[j] = pb[j] && cntb[j] == 0;
            yb[j] = yb_vld[j] ? rb[j] : 16'hBEEF;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Latency is counted to the clock edge that samples res_vld high.
    task automatic go(input logic [31:0] a0, a1, a2, input logic [31:0] exp,
                      input int lat_exp, input string tag, input bit hold);
        int n = 0;
        bit rdy_seen = 0;
        arg = {a2, a1, a0};
        arg_vld = 1;
        while (!arg_rdy && n < 50) begin @(posedge clk); #1; n++; end
        chk({tag, "_rdy"}, arg_rdy, 1);
        @(posedge clk); #1;
        arg_vld = hold;
        n = 0;
        while (!res_vld && n < 300) begin
            if (hold) arg = {$urandom, $urandom, $urandom};
            rdy_seen |= arg_rdy;
            @(posedge clk); #1;
            n++;
        end
        arg_vld = 0;
        chk({tag, "_lat"}, n + 1, lat_exp);
        chk({tag, "_res"}, res, exp);
        if (hold) chk({tag, "_busy"}, rdy_seen, 0);
    endtask

    initial begin
        int n;
        bit seen;
        logic [31:0] r0, r1, r2;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", arg_rdy, 1);
        chk("rst_res", res, 0);
        chk("rst_vld", res_vld, 0);
        chk("rst_xvld", xa_vld, 0);
        rst_n = 1;
        @(posedge clk); #1;

        go(16, 25, 36, 15, 11, "basic", 0);
        go(0, 1, 2, 2, 11, "small", 0);
        go(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 196605, 11, "ones", 0);
        arg = '0;
        arg_vld = 1;
        @(posedge clk); #1;
        chk("b2b_rdy", arg_rdy, 1);
        go(0, 0, 0, 0, 11, "zero", 0);

        go(100, 144, 169, 35, 11, "hold", 1);

        skew = 3; lat = 2;
        go(9, 16, 25, 12, 10, "skew", 0);
        skew = 0; lat = 4;

        arg = {32'd1, 32'd1, 32'd1};
        arg_vld = 1;
        @(posedge clk); #1;
        arg_vld = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("mid_rst_vld", res_vld, 0);
        chk("mid_rst_res", res, 0);
        chk("mid_rst_rdy", arg_rdy, 1);
        chk("mid_rst_xvld", xa_vld, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        seen = 0;
        repeat (20) begin @(posedge clk); #1; seen |= res_vld; end
        chk("mid_rst_novld", seen, 0);
        go(49, 64, 81, 24, 11, "after_rst", 0);

        argb = {32'd16, 32'd9, 32'd4, 32'd1};
        argb_vld = 1;
        @(posedge clk); #1;
        argb_vld = 0;
        n = 0;
        while (!resb_vld && n < 100) begin @(posedge clk); #1; n++; end
        chk("wide_lat", n + 1, 6);
        chk("wide_res", resb, 10);

        for (int k = 0; k < 1000; k++) begin
            lat = $urandom_range(1, 8);
            r0 = $urandom; r1 = $urandom; r2 = $urandom;
            go(r0, r1, r2, 32'(isq(r0)) + 32'(isq(r1)) + 32'(isq(r2)),
               2 * (lat + 1) + 1, "rand", 0);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/formula_sum_isqrt_fsm.md
FORMULA_SUM_ISQRT_FSM -- requirements
Module: formula_sum_isqrt_fsm

Interface
REQ-001 Parameter N_ARGS, default 3; number of arguments summed, legal range 1..16.
REQ-002 Parameter N_ISQRT, default 2; number of parallel isqrt instances, legal range 1..N_ARGS.
REQ-003 Parameter W, default 32; argument and result width, even, 8..64.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 arg_vld  input  1  argument set valid; accepted only while arg_rdy=1.
REQ-007 arg  input  N_ARGS x W  unsigned arguments; arg[i] is argument i.
REQ-008 arg_rdy  output  1  high only in IDLE.
REQ-009 res_vld  output  1  one-cycle pulse marking a new result.
REQ-010 res  output  W  sum over i of isqrt(arg[i]); holds its value between pulses.
REQ-011 isqrt_x_vld  output  N_ISQRT  per-lane request strobe.
REQ-012 isqrt_x  output  N_ISQRT x W  per-lane radicand.
REQ-013 isqrt_y_vld  input  N_ISQRT  per-lane result strobe.
REQ-014 isqrt_y  input  N_ISQRT x W/2  per-lane root.

Function
REQ-015 The block SHALL compute res = sum over i=0..N_ARGS-1 of isqrt(arg[i]), using the isqrt lanes in B = ceil(N_ARGS/N_ISQRT) batches.
REQ-016 The states SHALL be IDLE, ISSUE, WAIT and DONE.
REQ-017 In IDLE, when arg_vld=1, the block SHALL register all arguments, clear the accumulator and batch counter, and go to ISSUE.
REQ-018 arg_vld while arg_rdy=0 SHALL be ignored; the captured arguments SHALL NOT change.
REQ-019 In ISSUE, for one cycle, lane j SHALL drive isqrt_x = arg[batch*N_ISQRT+j] with isqrt_x_vld[j]=1 when that index is below N_ARGS; otherwise lane j is inactive, with x_vld=0 and isqrt_x=0; next state is WAIT.
REQ-020 isqrt_x_vld SHALL be 0 in every state other than ISSUE.
REQ-021 A batch SHALL complete in WAIT in the cycle where isqrt_y_vld is 1 on every active lane.
REQ-022 On batch completion, the zero-extended isqrt_y of active lanes SHALL be added to the accumulator; inactive-lane isqrt_y SHALL be ignored.
REQ-023 After batch completion, the next state SHALL be DONE for the last batch; otherwise the batch counter SHALL increment and the next state SHALL be ISSUE.
REQ-024 isqrt_y_vld outside WAIT, or asserted on only a subset of active lanes, SHALL be ignored.
REQ-025 In DONE, res SHALL equal the accumulator and res_vld=1 for exactly one cycle; next state is IDLE.
REQ-026 Accumulation SHALL be modulo 2^W.
REQ-027 With isqrt latency L cycles from x_vld to y_vld, res_vld SHALL assert B*(L+1)+1 cycles after the accepting arg_vld edge.
REQ-028 A new arg_vld SHALL be accepted in the cycle after DONE, with no dead cycle.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately force state IDLE, res_vld=0, res=0, accumulator=0, batch counter=0, isqrt_x_vld=0 and arg_rdy=1.
REQ-030 A reset mid-operation SHALL abandon the computation without emitting res_vld.
REQ-031 The isqrt instances SHALL share rst_n, so no stale y_vld survives reset.
REQ-032 Reset deassertion SHALL be synchronised externally; the block need not handle removal metastability.

Structure
REQ-033 The state enum typedef and the default parameter constants SHALL live in package sqrt_formula_pkg.
REQ-034 The masked per-lane sum SHALL be a combinational sub-module named isqrt_lane_sum, with N_ISQRT/W/2 parameters, inputs y and active mask, and output a W-bit sum.
REQ-035 Parameter legality SHALL be checked at elaboration; an illegal value SHALL be a fatal error.

Verification (isqrt model latency L=4 unless stated)
REQ-036 N_ARGS=3, N_ISQRT=2, args 16,25,36 -> res=15, res_vld 11 cycles after accept, lane 1 idle in batch 1.
REQ-037 N_ARGS=4, N_ISQRT=4, args 1,4,9,16 -> single batch, res=10, res_vld 6 cycles after accept.
REQ-038 N_ARGS=3, N_ISQRT=2, args all 0xFFFFFFFF -> res=196605; then args 0,0,0 issued the next cycle -> res=0.
REQ-039 arg_vld held high throughout a computation with changing arg -> only the first set is used; arg_rdy=0 until after DONE.
REQ-040 rst_n pulsed low during WAIT of batch 0 -> no res_vld; res=0; a following run with args 49,64,81 -> res=24.
REQ-041 Random L in 1..8 across 1000 random argument sets -> res matches the software sum of floor-sqrt modulo 2^W, and latency matches REQ-027.
